mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide datapath in the EX stage. It accepts one M-extension operation from decode, runs an iterative shift-add multiply or restoring divide over WORD_WIDTH cycles, and returns a 32-bit result. While an operation is outstanding it stalls the pipeline. Division special cases are handled in one cycle without iterating.

## Interface
- WORD_WIDTH, 32: operand and result width.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  decode presents an M operation.
- req_ready_o  out  1  block can accept a request; high only in IDLE.
- operator_i  in  3  funct3 encoding: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- operand_a_i  in  WORD_WIDTH  rs1 value.
- operand_b_i  in  WORD_WIDTH  rs2 value.
- flush_i  in  1  kills the in-flight operation.
- resp_valid_o  out  1  result_o is valid; high only in DONE.
- resp_ready_i  in  1  writeback accepts the result.
- result_o  out  WORD_WIDTH  operation result.
- stall_o  out  1  freezes IF/ID/EX; equals (state != IDLE) or req_valid_i, gated low while resp_valid_o & resp_ready_i.

## Operation
- FSM states: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE → PREP on req_valid_i & req_ready_o. Operator and operands are latched on this edge.
- IDLE → DONE directly on the accepting edge for these division special cases:
  - Divide by zero (b == 0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- PREP (1 cycle):
  - Take magnitudes of signed operands. Signed operands: a for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM.
  - Record result sign. Product and quotient sign = sa ^ sb. Remainder sign = sa.
  - Clear the 2*WORD_WIDTH accumulator and load iteration counter = WORD_WIDTH.
- CALC (WORD_WIDTH cycles): one bit per cycle.
  - Multiply: conditional add of |b| into the upper half, then shift right.
  - Divide: restoring shift-subtract.
  - Counter width is $clog2(WORD_WIDTH)+1. Decrement each cycle; go to FIXUP when counter == 1 on the decrementing edge.
- FIXUP (1 cycle):
  - Apply two's-complement negation if the sign is set.
  - Select the low product half (MUL), the high product half (MULH*), the quotient, or the remainder.
  - Register the selection into result_o.
- DONE: hold result_o and resp_valid_o until resp_ready_i, then go to IDLE on that edge. No new request is accepted in the same cycle.
- flush_i has priority over every transition: any state goes to IDLE next edge, resp_valid_o low, result discarded. A request presented in the flush cycle is not accepted.
- All arithmetic is modulo 2^WORD_WIDTH except the internal 2*WORD_WIDTH accumulator. No overflow flags.

## Timing
- Reset values: state IDLE, req_ready_o 1, resp_valid_o 0, result_o 0, stall_o = req_valid_i, counter 0.
- Normal latency: accept edge e0 → PREP → CALC from e1 through e32 → FIXUP after e33 → resp_valid_o high after e34. That is WORD_WIDTH+2 edges.
- Special-case latency: resp_valid_o high after e0, 1 edge.
- Back-to-back throughput: one operation per WORD_WIDTH+4 cycles at best, since DONE→IDLE costs one cycle.
- Backpressure: DONE holds indefinitely and result_o stays stable.
- Reset asserted mid-operation: FSM goes to IDLE on the next edge, outputs return to reset values, no response is produced.

## Structure
- Operator encodings (MDU_MUL … MDU_REMU), MDU_OP_WIDTH = 3, and the state enum typedef mdu_state_t go in riscv_defines alongside WORD_WIDTH.
- Sub-module mdu_iter_dp holds the datapath: accumulator, shift/add/subtract step, and sign negation. It is driven by step/load/fixup strobes.
- mdu_seq holds the FSM, counter, handshake, special-case detection, and stall generation.

## Test plan
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB; resp_valid_o rises exactly 34 edges after accept; stall_o high throughout.
- MULH a=b=0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 after 1 edge. DIVU 100/0 → 0xFFFFFFFF. REM 0x1234/0 → 0x1234, also after 1 edge.
- Signed division: DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. REMU 7/2 → 1.
- Backpressure: hold resp_ready_i low for 5 cycles in DONE → result_o stable, req_ready_o low; release → IDLE next edge, req_ready_o high.
- Flush at CALC cycle 10 → no resp_valid_o, IDLE next edge. A following DIVU 9/3 returns 3 in 34 edges. Repeat with rst_n low at the same point → identical recovery.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RV32M definitions: word width, M-extension funct3 codes and the
// sequencer state encoding used by the multiply/divide unit.
package riscv_defines;

    localparam int WORD_WIDTH   = 32;
    localparam int MDU_OP_WIDTH = 3;
    localparam int MDU_CNT_W    = $clog2(WORD_WIDTH) + 1;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIXUP,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter_dp.sv
// Iterative multiply/divide datapath: magnitude load, one shift-add or
// restoring shift-subtract per step, sign fixup and result register.
module mdu_iter_dp
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic                    fixup_i,
    input  logic                    spec_i,
    input  logic [WORD_WIDTH-1:0]   spec_res_i,
    input  logic [MDU_OP_WIDTH-1:0] op_i,
    input  logic [WORD_WIDTH-1:0]   a_i,
    input  logic [WORD_WIDTH-1:0]   b_i,
    output logic [WORD_WIDTH-1:0]   result_o
);

    localparam int W = WORD_WIDTH;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   bm_q, bm_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   result_q, result_d;

    logic           a_sgn, b_sgn, sa, sb;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, rem_sh, diff;
    logic           ge;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, sel;

    always_comb begin
        a_sgn = (op_i == MDU_MULH) || (op_i == MDU_MULHSU)
             || (op_i == MDU_DIV)  || (op_i == MDU_REM);
        b_sgn = (op_i == MDU_MULH) || (op_i == MDU_DIV) || (op_i == MDU_REM);
        sa    = a_sgn & a_i[W-1];
        sb    = b_sgn & b_i[W-1];
        mag_a = sa ? -a_i : a_i;
        mag_b = sb ? -b_i : b_i;

        // Multiply keeps the multiplier in the low half and shifts it out.
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, bm_q} : '0);
        rem_sh  = acc_q[2*W-1:W-1];
        diff    = rem_sh - {1'b0, bm_q};
        ge      = ~diff[W];

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        unique case (op_i)
            MDU_MUL:                        sel = prod_fix[W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: sel = prod_fix[2*W-1:W];
            MDU_DIV, MDU_DIVU:              sel = quo_fix;
            default:                        sel = rem_fix;
        endcase

        acc_d    = acc_q;
        bm_d     = bm_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (load_i) begin
            acc_d = {{W{1'b0}}, mag_a};
            bm_d  = mag_b;
            neg_d = (op_i == MDU_REM) ? sa : (sa ^ sb);
        end else if (step_i) begin
            if (op_i[2])
                acc_d = {ge ? diff[W-1:0] : rem_sh[W-1:0], acc_q[W-2:0], ge};
            else
                acc_d = {mul_sum, acc_q[W-1:1]};
        end

        if (spec_i)
            result_d = spec_res_i;
        else if (fixup_i)
            result_d = sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            bm_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            bm_q     <= bm_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/mdu_seq.sv
// RV32M multi-cycle sequencer: request/response handshake, iteration
// counter, single-cycle division special cases and pipeline stall.
module mdu_seq
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [MDU_OP_WIDTH-1:0] operator_i,
    input  logic [WORD_WIDTH-1:0]   operand_a_i,
    input  logic [WORD_WIDTH-1:0]   operand_b_i,
    input  logic                    flush_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [WORD_WIDTH-1:0]   result_o,
    output logic                    stall_o
);

    localparam int W = WORD_WIDTH;

    mdu_state_t               state_q, state_d;
    logic [MDU_CNT_W-1:0]     cnt_q, cnt_d;
    logic [MDU_OP_WIDTH-1:0]  op_q, op_d;
    logic [W-1:0]             a_q, a_d, b_q, b_d;

    logic         accept, is_div, div_zero, div_ovf, special;
    logic [W-1:0] spec_res;
    logic         load, step, fixup;

    always_comb begin
        accept   = req_valid_i & req_ready_o & ~flush_i;
        is_div   = operator_i[2];
        div_zero = is_div && (operand_b_i == '0);
        div_ovf  = is_div && !operator_i[0]
                && (operand_a_i == {1'b1, {(W-1){1'b0}}})
                && (operand_b_i == {W{1'b1}});
        special  = div_zero | div_ovf;

        // Quotient specials live at funct3[1]=0, remainder specials at 1.
        if (div_zero)
            spec_res = operator_i[1] ? operand_a_i : {W{1'b1}};
        else
            spec_res = operator_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d    = operator_i;
                        a_d     = operand_a_i;
                        b_d     = operand_b_i;
                        state_d = special ? DONE : PREP;
                    end
                end
                PREP: begin
                    cnt_d   = MDU_CNT_W'(W);
                    state_d = CALC;
                end
                CALC: begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                    if (cnt_q == MDU_CNT_W'(1))
                        state_d = FIXUP;
                end
                FIXUP: state_d = DONE;
                DONE: begin
                    if (resp_ready_i)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign load  = (state_q == PREP)  & ~flush_i;
    assign step  = (state_q == CALC)  & ~flush_i;
    assign fixup = (state_q == FIXUP) & ~flush_i;

    mdu_iter_dp u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .step_i     (step),
        .fixup_i    (fixup),
        .spec_i     (accept & special),
        .spec_res_i (spec_res),
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .result_o   (result_o)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign stall_o      = ((state_q != IDLE) | req_valid_i)
                        & ~(resp_valid_o & resp_ready_i);

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized self-checking bench for mdu_seq against an arithmetic
// reference model of the RV32M multiply/divide instructions.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  operator_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] result_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .operator_i   (operator_i),
        .operand_a_i  (operand_a_i),
        .operand_b_i  (operand_b_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .stall_o      (stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] op,
                                        input logic [31:0] a, b);
        if (!op[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000
               && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                            input logic [31:0] a, b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        up;
        logic signed [31:0] q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        up = {32'h0, a} * {32'h0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called #1 after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, b, input int hold);
        int          lat;
        int          exp_lat;
        logic        stall_ok;
        logic [31:0] exp;
        exp     = ref_mdu(op, a, b);
        exp_lat = is_special(op, a, b) ? 0 : 34;
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        lat      = 0;
        stall_ok = 1'b1;
        while (!resp_valid_o && lat < 100) begin
            if (!stall_o || req_ready_o) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall"}, 32'(stall_ok), 32'd1);
        chk({tag, "_res"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_res"}, result_o, exp);
            chk({tag, "_hold_flags"},
                {29'h0, resp_valid_o, req_ready_o, stall_o}, 32'b101);
        end
        resp_ready_i = 1'b1;
        #1;
        chk({tag, "_hs_stall"}, 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        chk({tag, "_idle"}, {30'h0, resp_valid_o, req_ready_o}, 32'b01);
    endtask

    // Start a multiply, then kill it in CALC with flush or reset.
    task automatic abort_mid(input string tag, input logic use_rst);
        int seen;
        operator_i  = 3'd0;
        operand_a_i = 32'h1234_5678;
        operand_b_i = 32'h9ABC_DEF0;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst_n = 1'b0;
        else flush_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        flush_i = 1'b0;
        chk({tag, "_idle"}, {30'h0, resp_valid_o, req_ready_o}, 32'b01);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        if (use_rst) chk({tag, "_res0"}, result_o, 32'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid_o) seen++;
        end
        chk({tag, "_noresp"}, 32'(seen), 32'd0);
        run_op({tag, "_divu"}, 3'd5, 32'd9, 32'd3, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          r;
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        operator_i   = 3'd0;
        operand_a_i  = 32'h0;
        operand_b_i  = 32'h0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {29'h0, req_ready_o, resp_valid_o, stall_o}, 32'b100);
        chk("rst_res", result_o, 32'h0);
        req_valid_i = 1'b1;
        #1;
        chk("rst_stall_req", 32'(stall_o), 32'd1);
        req_valid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 0);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_0", 3'd5, 32'd100,       32'd0,         0);
        run_op("rem_0",  3'd6, 32'h1234,      32'd0,         0);
        run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div",    3'd4, -32'sd7,       32'd2,         0);
        run_op("rem",    3'd6, -32'sd7,       32'd2,         0);
        run_op("remu",   3'd7, 32'd7,         32'd2,         5);

        // Request presented together with flush must be dropped.
        operator_i  = 3'd5;
        operand_a_i = 32'd1;
        operand_b_i = 32'd0;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_req_drop", {30'h0, resp_valid_o, req_ready_o}, 32'b01);

        abort_mid("flush", 1'b0);
        abort_mid("reset", 1'b1);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'h0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) b = -32'($urandom_range(1, 15));
            run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
